// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t  : receiver FSM state encoding
//   OS_DEFAULT  : default oversampling ratio (ticks per bit)
//   s_cnt_w()   : width of the oversampling tick counter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OS_DEFAULT = 16;

  // Tick counter must reach both OS-1 (data bits) and SB_TICK-1 (stop bit).
  function automatic int unsigned s_cnt_w(input int unsigned os, input int unsigned sb_tick);
    return (os > sb_tick) ? $clog2(os) : $clog2(sb_tick);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk     : destination clock
//   rst     : asynchronous active-high reset, loads RST_VAL into both flops
//   d       : asynchronous input
//   q       : synchronised output (2 clk latency)
// Parameter RST_VAL selects the reset/idle level of the line.
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by an OS x baud tick from the baud generator.
// Synchronises rx, finds the start bit by mid-bit sampling, shifts in
// LSB-first data, checks the stop bit and presents each good word through
// a valid/ready handshake.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   tick       : one-cycle pulse at OS x baud rate
//   rx         : asynchronous serial input, idle high
//   rx_data    : received word, stable while rx_valid=1
//   rx_valid   : word available, held until rx_valid & rx_ready
//   rx_ready   : consumer accepts rx_data
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good frame arrived while previous word unconsumed
//   busy       : FSM not in IDLE
//   parity_err : (UART_RX_PARITY_EN only) one-cycle pulse, parity mismatch
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY_ODD, parity_err,
// and a parity bit between data and stop).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned OS      = OS_DEFAULT
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int unsigned SW = s_cnt_w(OS, SB_TICK);
  localparam int unsigned NW = $clog2(DBIT + 1);

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;

  rx_state_t       state_q, state_n;
  logic [SW-1:0]   s_q, s_n;
  logic [NW-1:0]   n_q, n_n;
  logic [DBIT-1:0] b_q, b_n;
  logic            done;
  logic            ferr;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_n;
  logic            perr;
`endif

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync_rx (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      n_q     <= n_n;
      b_q     <= b_n;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    n_n     = n_q;
    b_n     = b_q;
    done    = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Level-based start detection; does not wait for a tick.
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_HALF) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            s_n = '0;
            b_n = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n_q + NW'(1);
            end
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            par_n   = rx_s;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            if (rx_s) begin
              state_n = IDLE;
`ifdef UART_RX_PARITY_EN
              // Framing is checked first, so parity_err never accompanies frame_err.
              if (par_q != ((^b_q) ^ PARITY_ODD)) begin
                perr = 1'b1;
              end else begin
                done = 1'b1;
              end
`else
              done = 1'b1;
`endif
            end else begin
              ferr    = 1'b1;
              state_n = BREAK;
            end
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
      BREAK: begin
        // Hold here while the line stays low so a break cannot retrigger START.
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output buffer: a completing frame may replace a word consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= ferr;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr;
`endif
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= b_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
